tt_um_jimktrains_vslc_timer_bank: RTL and testbench
===================================================

# tt_um_jimktrains_vslc_timer_bank

Parametrised bank of independent PWM/interval timers for the VSLC I/O section. Each channel has separate low- and high-phase periods, free-running or one-shot mode, a restart trigger and a per-period wrap pulse. The bank replaces single 8-bit symmetric timers wherever the VSLC needs several timed outputs or asymmetric duty cycles.

## Interface
- `WIDTH`, 8: counter and period width in bits (2..16).
- `CHANNELS`, 4: number of independent channels (1..8).

- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `period_lo`  in  CHANNELS*WIDTH  low-phase period. Channel c uses slice [c*WIDTH +: WIDTH].
- `period_hi`  in  CHANNELS*WIDTH  high-phase period, same slicing.
- `enable`  in  CHANNELS  per-channel run enable (level).
- `oneshot`  in  CHANNELS  1 = stop after one full period, 0 = free-running.
- `trigger`  in  CHANNELS  single-cycle restart request.
- `timer_output`  out  CHANNELS  registered timer output.
- `wrap`  out  CHANNELS  one-cycle pulse when a full period ends.
- `busy`  out  CHANNELS  1 while the channel is in LOW or HIGH.

## Operation
- Per-channel states:
  - IDLE: not enabled.
  - LOW: output 0.
  - HIGH: output 1.
  - DONE: one-shot finished.
- Counter is WIDTH bits, cleared on every state change, and increments by 1 each cycle in LOW and HIGH.
- Transitions out of IDLE and DONE:
  - IDLE, enable=1 → LOW, counter 0.
  - DONE: holds with output 0 until trigger or enable=0.
- LOW, when counter ≥ period_lo (LOW lasts period_lo+1 cycles):
  - period_hi ≠ 0 → HIGH, output 1.
  - period_hi = 0 → HIGH is skipped, output stays 0, and the period ends here.
- HIGH, when counter+1 ≥ period_hi (HIGH lasts period_hi cycles): output 0 and the period ends.
- End of period:
  - `wrap` pulses for one cycle.
  - oneshot=0 → LOW.
  - oneshot=1 → DONE.
- Comparisons use ≥, evaluated in WIDTH+1 bits. A period lowered mid-phase below the current count ends that phase on the next edge, so the counter never wraps through 2^WIDTH.
- Periods and `oneshot` are sampled live every cycle and are not latched.
- Priority, highest first:
  1. enable=0: → IDLE, output 0, counter 0.
  2. trigger (while enabled, any state): → LOW, counter 0, output 0, no `wrap`.
  3. terminal count.
- trigger with enable=0 is ignored.
- Channels share nothing but clk and rst_n; events on one channel never affect another.

## Timing
- Reset (asynchronous, immediate): every channel IDLE, counter 0, `timer_output`=0, `wrap`=0, `busy`=0.
- All outputs are registered and there is no combinational input→output path.
- enable sampled 1 at edge N → `busy`=1 after edge N; the first HIGH begins period_lo+1 cycles later.
- Free-running period = period_lo + 1 + period_hi cycles. The duty cycle is period_hi / that period.
- `wrap` is asserted in the same cycle as the falling edge of `timer_output`, or the LOW restart when period_hi=0.
- Leaving HIGH or DONE drives `timer_output` to 0 in the same update.

## Structure
- Package `vslc_timer_pkg`: state encoding constants (IDLE=0, LOW=1, HIGH=2, DONE=3) and the default WIDTH.
- Sub-module `tt_um_jimktrains_vslc_timer_chan`: one channel (counter, FSM, output registers), parametrised by WIDTH.
- The top level instantiates it CHANNELS times in a generate loop and slices the period buses.

## Test plan
- Reset and IDLE check: assert rst_n=0 mid-HIGH with counter nonzero. Required: `timer_output`, `busy` and `wrap` go to 0 immediately, without waiting for a clock edge.
- Free-running, WIDTH=8, period_lo=2, period_hi=3, enable held 1:
  - output pattern 000111 repeating, starting from the edge after enable is sampled.
  - `wrap` asserted in the cycle of each falling edge.
- One-shot, period_lo=1, period_hi=1:
  - output 0,0,1, then 0 forever.
  - one `wrap` pulse, after which `busy`=0.
  - trigger → pattern repeats once.
- period_hi=0:
  - output stays 0.
  - with period_lo=4, `wrap` pulses every 5 cycles.
  - in one-shot mode, DONE is reached after 5 cycles.
- Mid-phase changes and priority:
  - In HIGH with counter=6, period_hi changed 10→3 → HIGH ends at the next edge.
  - trigger and terminal count in the same cycle → LOW restart, no `wrap`.
  - enable=0 together with trigger → IDLE.
- Channel independence, CHANNELS=4: run distinct periods on all four channels, toggling enable and trigger on channel 2 only. Required: channels 0, 1 and 3 match reference waveforms cycle-exactly.

Source files
------------

// File: rtl/vslc_timer_pkg.sv
// vslc_timer_pkg: shared state encoding and defaults for the VSLC timer bank
package vslc_timer_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;
    localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/tt_um_jimktrains_vslc_timer_chan.sv
// tt_um_jimktrains_vslc_timer_chan: one asymmetric PWM/interval timer channel
module tt_um_jimktrains_vslc_timer_chan
    import vslc_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] period_lo,
    input  logic [WIDTH-1:0] period_hi,
    input  logic             enable,
    input  logic             oneshot,
    input  logic             trigger,
    output logic             timer_output,
    output logic             wrap,
    output logic             busy
);
    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic             r_out;
    logic             r_wrap;
    logic [WIDTH:0]   w_cnt_ext;
    logic             w_lo_done;
    logic             w_hi_done;
    logic             w_end;

    // Compare one bit wider than the counter so a lowered period ends the phase instead of wrapping
    assign w_cnt_ext = {1'b0, r_cnt};
    assign w_lo_done = w_cnt_ext >= {1'b0, period_lo};
    assign w_hi_done = (w_cnt_ext + {{WIDTH{1'b0}}, 1'b1}) >= {1'b0, period_hi};
    assign w_end     = (r_state == ST_LOW && w_lo_done && period_hi == '0) || (r_state == ST_HIGH && w_hi_done);

    // Channel FSM: enable beats trigger beats terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (!enable) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (trigger) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= w_end;
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_LOW;
                    r_cnt   <= '0;
                    r_out   <= 1'b0;
                end
                ST_LOW: begin
                    if (w_lo_done) begin
                        r_cnt   <= '0;
                        r_out   <= period_hi != '0;
                        r_state <= period_hi != '0 ? ST_HIGH : (oneshot ? ST_DONE : ST_LOW);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (w_hi_done) begin
                        r_cnt   <= '0;
                        r_out   <= 1'b0;
                        r_state <= oneshot ? ST_DONE : ST_LOW;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_out <= 1'b0;
            endcase
        end
    end

    assign timer_output = r_out;
    assign wrap         = r_wrap;
    assign busy         = r_state == ST_LOW || r_state == ST_HIGH;
endmodule

// File: rtl/tt_um_jimktrains_vslc_timer_bank.sv
// tt_um_jimktrains_vslc_timer_bank: bank of independent PWM/interval timer channels
module tt_um_jimktrains_vslc_timer_bank
    import vslc_timer_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] period_lo,
    input  logic [CHANNELS*WIDTH-1:0] period_hi,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       oneshot,
    input  logic [CHANNELS-1:0]       trigger,
    output logic [CHANNELS-1:0]       timer_output,
    output logic [CHANNELS-1:0]       wrap,
    output logic [CHANNELS-1:0]       busy
);
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        tt_um_jimktrains_vslc_timer_chan #(.WIDTH(WIDTH)) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .period_lo   (period_lo[c*WIDTH +: WIDTH]),
            .period_hi   (period_hi[c*WIDTH +: WIDTH]),
            .enable      (enable[c]),
            .oneshot     (oneshot[c]),
            .trigger     (trigger[c]),
            .timer_output(timer_output[c]),
            .wrap        (wrap[c]),
            .busy        (busy[c])
        );
    end
endmodule

// File: tb/tb_tt_um_jimktrains_vslc_timer_bank.sv
// tb_tt_um_jimktrains_vslc_timer_bank: scoreboard bench for the timer bank
module tb_tt_um_jimktrains_vslc_timer_bank;
    localparam int W = 8;
    localparam int C = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [C*W-1:0] period_lo = '0;
    logic [C*W-1:0] period_hi = '0;
    logic [C-1:0]   enable = '0;
    logic [C-1:0]   oneshot = '0;
    logic [C-1:0]   trigger = '0;
    logic [C-1:0]   timer_output;
    logic [C-1:0]   wrap;
    logic [C-1:0]   busy;

    int n_chk = 0;
    int n_pass = 0;
    int m_st[C];
    int m_cnt[C];
    logic [C-1:0] m_out;
    logic [C-1:0] m_wrap;
    logic [3*C-1:0] exp_q[$];
    string tag_q[$];
    logic [15:0] s_out, s_wrap, s_busy;

    tt_um_jimktrains_vslc_timer_bank #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk(clk), .rst_n(rst_n), .period_lo(period_lo), .period_hi(period_hi),
        .enable(enable), .oneshot(oneshot), .trigger(trigger),
        .timer_output(timer_output), .wrap(wrap), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int c = 0; c < C; c++) begin
            m_st[c] = 0;
            m_cnt[c] = 0;
        end
        m_out = '0;
        m_wrap = '0;
    endtask

    // Reference: states 0 idle, 1 low, 2 high, 3 done; counts are plain ints
    task automatic model_step();
        for (int c = 0; c < C; c++) begin
            int lo;
            int hi;
            lo = int'(period_lo[c*W +: W]);
            hi = int'(period_hi[c*W +: W]);
            m_wrap[c] = 1'b0;
            if (!enable[c]) begin
                m_st[c] = 0; m_cnt[c] = 0; m_out[c] = 1'b0;
            end else if (trigger[c]) begin
                m_st[c] = 1; m_cnt[c] = 0; m_out[c] = 1'b0;
            end else if (m_st[c] == 0) begin
                m_st[c] = 1; m_cnt[c] = 0;
            end else if (m_st[c] == 1) begin
                if (m_cnt[c] < lo) m_cnt[c]++;
                else if (hi > 0) begin
                    m_st[c] = 2; m_cnt[c] = 0; m_out[c] = 1'b1;
                end else begin
                    m_cnt[c] = 0; m_wrap[c] = 1'b1; m_st[c] = oneshot[c] ? 3 : 1;
                end
            end else if (m_st[c] == 2) begin
                if (m_cnt[c] + 1 < hi) m_cnt[c]++;
                else begin
                    m_cnt[c] = 0; m_out[c] = 1'b0; m_wrap[c] = 1'b1; m_st[c] = oneshot[c] ? 3 : 1;
                end
            end else m_out[c] = 1'b0;
        end
    endtask

    function automatic logic [3*C-1:0] model_vec();
        logic [C-1:0] b;
        for (int c = 0; c < C; c++) b[c] = m_st[c] == 1 || m_st[c] == 2;
        return {b, m_wrap, m_out};
    endfunction

    task automatic cyc(input string tag);
        logic [3*C-1:0] e;
        string t;
        model_step();
        exp_q.push_back(model_vec());
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        trigger = '0;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, {busy, wrap, timer_output}, e);
        s_out  = {s_out[14:0], timer_output[0]};
        s_wrap = {s_wrap[14:0], wrap[0]};
        s_busy = {s_busy[14:0], busy[0]};
    endtask

    task automatic set_ch(input int c, input int lo, input int hi);
        period_lo[c*W +: W] = W'(lo);
        period_hi[c*W +: W] = W'(hi);
    endtask

    task automatic clr();
        s_out = '0; s_wrap = '0; s_busy = '0;
    endtask

    initial begin
        int nw0;
        int nw3;
        model_reset();
        clr();
        #1 rst_n = 1'b0;
        #1;
        check("rst_out", timer_output, 0);
        check("rst_busy", busy, 0);
        check("rst_wrap", wrap, 0);
        @(negedge clk) rst_n = 1'b1;

        set_ch(0, 2, 3);
        enable[0] = 1'b1;
        clr();
        repeat (12) cyc("fr");
        check("fr_out", s_out[11:0], 12'b000111000111);
        check("fr_wrap", s_wrap[11:0], 12'b000000100000);
        check("fr_mid_high", timer_output[0], 1);

        rst_n = 1'b0;
        #1;
        check("arst_out", timer_output, 0);
        check("arst_busy", busy, 0);
        check("arst_wrap", wrap, 0);
        enable = '0;
        model_reset();
        @(negedge clk) rst_n = 1'b1;

        set_ch(0, 1, 1);
        oneshot[0] = 1'b1;
        enable[0] = 1'b1;
        clr();
        repeat (8) cyc("os");
        check("os_out", s_out[7:0], 8'b00100000);
        check("os_busy", s_busy[7:0], 8'b11100000);
        check("os_wrap", s_wrap[7:0], 8'b00010000);
        trigger[0] = 1'b1;
        clr();
        repeat (6) cyc("os_trg");
        check("os_trg_out", s_out[5:0], 6'b001000);
        check("os_trg_wrap", s_wrap[5:0], 6'b000100);

        enable[0] = 1'b0;
        oneshot[0] = 1'b0;
        cyc("idle");
        set_ch(0, 4, 0);
        enable[0] = 1'b1;
        clr();
        repeat (12) cyc("p0");
        check("p0_out", s_out[11:0], 12'b0);
        check("p0_wrap", s_wrap[11:0], 12'b000001000010);
        enable[0] = 1'b0;
        cyc("idle");
        oneshot[0] = 1'b1;
        enable[0] = 1'b1;
        clr();
        repeat (8) cyc("p0os");
        check("p0os_busy", s_busy[7:0], 8'b11111000);
        check("p0os_wrap", s_wrap[7:0], 8'b00000100);

        enable[0] = 1'b0;
        oneshot[0] = 1'b0;
        cyc("idle");
        set_ch(0, 0, 10);
        enable[0] = 1'b1;
        repeat (8) cyc("mid");
        check("mid_high", timer_output[0], 1);
        set_ch(0, 0, 3);
        cyc("mid");
        check("mid_end", {wrap[0], timer_output[0]}, 2'b10);

        set_ch(0, 1, 1);
        enable[0] = 1'b0;
        cyc("idle");
        enable[0] = 1'b1;
        repeat (3) cyc("tt");
        check("tt_high", timer_output[0], 1);
        trigger[0] = 1'b1;
        cyc("tt");
        check("trg_tc", {busy[0], wrap[0], timer_output[0]}, 3'b100);
        enable[0] = 1'b0;
        trigger[0] = 1'b1;
        cyc("dis");
        check("dis_trg", {busy[0], timer_output[0]}, 0);

        cyc("idle");
        set_ch(0, 3, 5);
        set_ch(1, 0, 1);
        set_ch(2, 2, 2);
        set_ch(3, 5, 7);
        oneshot = '0;
        enable = '1;
        nw0 = 0;
        nw3 = 0;
        for (int i = 0; i < 180; i++) begin
            enable[2] = $urandom_range(0, 9) != 0;
            trigger[2] = $urandom_range(0, 5) == 0;
            cyc("ind");
            nw0 += int'(wrap[0]);
            nw3 += int'(wrap[3]);
        end
        check("ind_wraps0", nw0, 19);
        check("ind_wraps3", nw3, 13);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
